// File: rtl/pwm_pkg.sv
// Shared widths and types for the PWM period and duty-cycle counters.
package pwm_pkg;
    localparam int PWM_CNT_W   = 32;
    localparam int PWM_SEG_W   = 8;
    localparam int PWM_PRESC_W = 8;

    typedef logic [PWM_CNT_W-1:0] pwm_cnt_t;
endpackage

// File: rtl/pwm_cnt_seg.sv
// One slice of the segmented period down-counter.
// The zero flag is registered, so a borrow never ripples through segment values.
module pwm_cnt_seg #(
    parameter int SEG_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             dec,
    input  logic [SEG_W-1:0] load_val,
    output logic [SEG_W-1:0] seg,
    output logic             zero
);
    // zero always equals (seg == 0); it is computed from the value being written
    always_ff @(posedge clk) begin
        if (rst) begin
            seg  <= '0;
            zero <= 1'b1;
        end else if (load) begin
            seg  <= load_val;
            zero <= (load_val == '0);
        end else if (dec) begin
            seg  <= seg - 1'b1;
            zero <= (seg == SEG_W'(1));
        end
    end
endmodule

// File: rtl/pwm_period_gen.sv
// Prescaled PWM period generator built from a segmented down-counter.
// Define PWM_PERIOD_LIVE_CNT_EN to get a registered live copy of the counter on CUR_CNT.
module pwm_period_gen
    import pwm_pkg::*;
#(
    parameter int CNT_W   = PWM_CNT_W,
    parameter int SEG_W   = PWM_SEG_W,
    parameter int PRESC_W = PWM_PRESC_W
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               PWM_EN,
    input  logic               ONE_SHOT,
    input  logic               PERIOD_TOGGLE,
    input  logic [CNT_W-1:0]   PERIOD_REG,
    input  logic [PRESC_W-1:0] PRESC_REG,
    output logic               FREQ_COUNTER_EN,
    output logic               RUNNING,
    output logic               DONE,
    output logic [CNT_W-1:0]   CUR_CNT
);
    // CNT_W must be a whole number of segments
    localparam int NSEG = CNT_W / SEG_W;

    logic [CNT_W-1:0]   period_sh;
    logic [CNT_W-1:0]   cnt;
    logic [PRESC_W-1:0] presc_sh;
    logic [PRESC_W-1:0] presc_cnt;
    logic [NSEG-1:0]    seg_zero;
    logic [NSEG-1:0]    seg_dec;
    logic [NSEG-1:0]    low_zero;
    logic               active;
    logic               tick;
    logic               cnt_zero;
    logic               tc;
    logic               cnt_load;

    always_comb begin
        active   = PWM_EN && !DONE;
        tick     = (presc_cnt == presc_sh);
        cnt_zero = &seg_zero;
        tc       = active && tick && cnt_zero;
        cnt_load = !PWM_EN || tc;
    end

    assign low_zero[0] = 1'b1;

    genvar g;
    generate
        for (g = 0; g < NSEG; g++) begin : g_seg
            if (g > 0) begin : g_chain
                assign low_zero[g] = low_zero[g-1] & seg_zero[g-1];
            end
            // a segment borrows only when every segment below it is at zero
            assign seg_dec[g] = active && tick && !cnt_zero && low_zero[g];

            pwm_cnt_seg #(.SEG_W(SEG_W)) u_seg (
                .clk      (CLK),
                .rst      (RST),
                .load     (cnt_load),
                .dec      (seg_dec[g]),
                .load_val (period_sh[g*SEG_W +: SEG_W]),
                .seg      (cnt[g*SEG_W +: SEG_W]),
                .zero     (seg_zero[g])
            );
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (RST) begin
            period_sh       <= '0;
            presc_sh        <= '0;
            presc_cnt       <= '0;
            FREQ_COUNTER_EN <= 1'b0;
            RUNNING         <= 1'b0;
            DONE            <= 1'b0;
        end else begin
            if (!PWM_EN || PERIOD_TOGGLE) begin
                period_sh <= PERIOD_REG;
                presc_sh  <= PRESC_REG;
            end
            FREQ_COUNTER_EN <= tc;
            if (!PWM_EN) begin
                presc_cnt <= '0;
                DONE      <= 1'b0;
                RUNNING   <= 1'b0;
            end else if (!DONE) begin
                presc_cnt <= tick ? '0 : presc_cnt + 1'b1;
                if (tc && ONE_SHOT) begin
                    DONE    <= 1'b1;
                    RUNNING <= 1'b0;
                end else begin
                    RUNNING <= 1'b1;
                end
            end else begin
                RUNNING <= 1'b0;
            end
        end
    end

`ifdef PWM_PERIOD_LIVE_CNT_EN
    always_ff @(posedge CLK) begin
        if (RST) CUR_CNT <= '0;
        else     CUR_CNT <= cnt;
    end
`else
    assign CUR_CNT = '0;
`endif
endmodule

// File: tb/tb_pwm_period_gen.sv
// Directed bench for pwm_period_gen with a cycle-position reference model.
module tb_pwm_period_gen;
    import pwm_pkg::*;

    logic       clk = 1'b0;
    logic       rst, en, os, tog;
    pwm_cnt_t   preg;
    logic [7:0] qreg;
    logic       pulse, running, done;
    pwm_cnt_t   cur;

    int n_checks = 0;
    int n_err    = 0;
    bit chk_on   = 1'b0;

    pwm_period_gen dut (
        .CLK             (clk),
        .RST             (rst),
        .PWM_EN          (en),
        .ONE_SHOT        (os),
        .PERIOD_TOGGLE   (tog),
        .PERIOD_REG      (preg),
        .PRESC_REG       (qreg),
        .FREQ_COUNTER_EN (pulse),
        .RUNNING         (running),
        .DONE            (done),
        .CUR_CNT         (cur)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a period is (P+1)*(Q+1) cycles long, counted from the cycle it starts.
    longint   m_pos;
    pwm_cnt_t m_p, m_pcur;
    logic [7:0] m_q;
    bit       m_pulse, m_run, m_done;

    always @(posedge clk) begin : model
        longint len;
        pwm_cnt_t nxt_p;
        logic [7:0] nxt_q;
        if (rst) begin
            m_p = '0; m_q = '0; m_pcur = '0; m_pos = 0;
            m_pulse = 0; m_run = 0; m_done = 0;
        end else begin
            nxt_p = (!en || tog) ? preg : m_p;
            nxt_q = (!en || tog) ? qreg : m_q;
            if (!en) begin
                m_pcur = m_p; m_pos = 0;
                m_pulse = 0; m_run = 0; m_done = 0;
            end else if (!m_done) begin
                len = (longint'(m_pcur) + 1) * (longint'(m_q) + 1);
                if (m_pos == len - 1) begin
                    m_pulse = 1; m_pcur = m_p; m_pos = 0;
                    m_done = os; m_run = !os;
                end else begin
                    m_pulse = 0; m_pos++; m_run = 1;
                end
            end else begin
                m_pulse = 0; m_run = 0;
            end
            m_p = nxt_p; m_q = nxt_q;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check("model_pulse", longint'(pulse), longint'(m_pulse));
            check("model_running", longint'(running), longint'(m_run));
            check("model_done", longint'(done), longint'(m_done));
`ifndef PWM_PERIOD_LIVE_CNT_EN
            check("cur_cnt_tied", longint'(cur), 0);
`endif
        end
    end

    task automatic idle(input pwm_cnt_t p, input logic [7:0] q, input int n);
        preg = p; qreg = q; en = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; os = 1'b0; tog = 1'b0; preg = '0; qreg = '0;
        repeat (2) @(negedge clk);
        check("rst_pulse", longint'(pulse), 0);
        check("rst_running", longint'(running), 0);
        check("rst_done", longint'(done), 0);
        check("rst_cur", longint'(cur), 0);
        rst = 1'b0;
        chk_on = 1'b1;

        // P=3, Q=0: pulse after e3, e7, e11
        idle(3, 0, 3); en = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            check("t1_pulse", longint'(pulse), longint'(k % 4 == 3));
        end

        // P=2, Q=1: every 6 cycles; then P=0, Q=0: every cycle
        idle(2, 1, 3); en = 1'b1;
        for (int k = 0; k < 18; k++) begin
            @(negedge clk);
            check("t2_pulse", longint'(pulse), longint'(k % 6 == 5));
        end
        idle(0, 0, 3); en = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("t2_every", longint'(pulse), 1);
        end

        // P=0x1FF crosses the first segment boundary
        idle(32'h1FF, 0, 3); en = 1'b1;
        for (int k = 0; k < 1600; k++) begin
            @(negedge clk);
            if (k == 511 || k == 1022 || k == 1023 || k == 1535)
                check("t3_pulse", longint'(pulse), longint'(k != 1022));
        end

        // shadow update mid-period only affects the next period
        idle(3, 0, 3); en = 1'b1;
        for (int k = 0; k < 28; k++) begin
            @(negedge clk);
            check("t4_pulse", longint'(pulse),
                  longint'(k == 3 || k == 7 || k == 11 || k == 19 || k == 27));
            if (k == 8) begin preg = 7; tog = 1'b1; end
            if (k == 9) tog = 1'b0;
        end

        // one-shot, then restart after one idle cycle
        idle(4, 0, 3); os = 1'b1; en = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            check("t5_pulse", longint'(pulse), longint'(k == 4));
            check("t5_done", longint'(done), longint'(k >= 4));
            check("t5_running", longint'(running), longint'(k < 4));
        end
        en = 1'b0;
        @(negedge clk);
        check("t5_done_clr", longint'(done), 0);
        en = 1'b1; os = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("t5_restart", longint'(pulse), longint'(k == 4 || k == 9));
        end

        // reset mid-period, then reload and restart
        idle(5, 1, 3); en = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("t6_pulse", longint'(pulse), 0);
        check("t6_running", longint'(running), 0);
        check("t6_done", longint'(done), 0);
        check("t6_cur", longint'(cur), 0);
        rst = 1'b0; en = 1'b0;
        repeat (3) @(negedge clk);
        en = 1'b1;
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            check("t6_pulse_after", longint'(pulse), longint'(k == 11 || k == 23));
        end

        chk_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
